// File: rtl/lpm_lookup_scheduler.sv
// rtl/lpm_lookup_scheduler.sv - round-robin shared sequential longest-prefix-match engine
//
// Several requesters share one longest-prefix-match search engine. A round-robin
// arbiter grants one lookup at a time. The engine then checks one table entry per
// cycle. The result is held on the response port, tagged with the requester id.
// The block also owns the table write port, which takes priority over new grants
// while idle.
//
// Ports:
//   clk, reset                       clock and asynchronous active-high reset
//   req_valid/req_addr/req_ready     per-requester lookup handshake (one-hot grant)
//   cfg_we/cfg_idx/cfg_prefix/
//   cfg_len/cfg_en/cfg_ready         table write port (accepted only while idle)
//   resp_valid/resp_ready            result handshake
//   resp_id/resp_hit/
//   resp_prefix/resp_len             result payload
module lpm_lookup_scheduler #(
    parameter int NUM_REQ     = 4,
    parameter int NUM_ENTRIES = 4,
    parameter int IDX_W       = 2,
    parameter int ID_W        = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUM_REQ-1:0]     req_valid,
    input  logic [NUM_REQ*32-1:0]  req_addr,
    output logic [NUM_REQ-1:0]     req_ready,
    input  logic                   cfg_we,
    input  logic [IDX_W-1:0]       cfg_idx,
    input  logic [31:0]            cfg_prefix,
    input  logic [5:0]             cfg_len,
    input  logic                   cfg_en,
    output logic                   cfg_ready,
    output logic                   resp_valid,
    input  logic                   resp_ready,
    output logic [ID_W-1:0]        resp_id,
    output logic                   resp_hit,
    output logic [31:0]            resp_prefix,
    output logic [5:0]             resp_len
);

    typedef enum logic [1:0] {S_IDLE, S_SEARCH, S_RESP} state_t;

    state_t                 state_q, state_d;
    logic [ID_W-1:0]        rr_ptr_q, rr_ptr_d;
    logic [31:0]            addr_q, addr_d;
    logic [ID_W-1:0]        id_q, id_d;
    logic [IDX_W-1:0]       k_q, k_d;
    logic                   best_hit_q, best_hit_d;
    logic [31:0]            best_prefix_q, best_prefix_d;
    logic [5:0]             best_len_q, best_len_d;
    logic                   resp_valid_q, resp_valid_d;
    logic [NUM_ENTRIES-1:0] tbl_valid_q, tbl_valid_d;
    logic [31:0]            tbl_prefix_q [NUM_ENTRIES];
    logic [31:0]            tbl_prefix_d [NUM_ENTRIES];
    logic [5:0]             tbl_len_q [NUM_ENTRIES];
    logic [5:0]             tbl_len_d [NUM_ENTRIES];

    logic [NUM_REQ-1:0]     grant_c;
    logic                   found_c;
    int                     gidx_c;
    logic [31:0]            mask_c;

    // Leading-ones mask of the given length; a zero length matches everything.
    function automatic logic [31:0] len_mask(input logic [5:0] len);
        if (len == 6'd0) return 32'h0;
        return 32'hFFFF_FFFF << (6'd32 - len);
    endfunction

    always_comb begin
        state_d       = state_q;
        rr_ptr_d      = rr_ptr_q;
        addr_d        = addr_q;
        id_d          = id_q;
        k_d           = k_q;
        best_hit_d    = best_hit_q;
        best_prefix_d = best_prefix_q;
        best_len_d    = best_len_q;
        resp_valid_d  = resp_valid_q;
        tbl_valid_d   = tbl_valid_q;
        tbl_prefix_d  = tbl_prefix_q;
        tbl_len_d     = tbl_len_q;
        grant_c       = '0;
        found_c       = 1'b0;
        gidx_c        = 0;
        mask_c        = len_mask(tbl_len_q[k_q]);

        // First requester at or after the round-robin pointer, wrapping.
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!found_c && req_valid[(int'(rr_ptr_q) + i) % NUM_REQ]) begin
                found_c = 1'b1;
                gidx_c  = (int'(rr_ptr_q) + i) % NUM_REQ;
            end
        end

        case (state_q)
            S_IDLE: begin
                if (cfg_we) begin
                    tbl_prefix_d[cfg_idx] = cfg_prefix;
                    tbl_len_d[cfg_idx]    = (cfg_len > 6'd32) ? 6'd32 : cfg_len;
                    tbl_valid_d[cfg_idx]  = cfg_en;
                end else if (found_c) begin
                    grant_c[gidx_c] = 1'b1;
                    addr_d          = req_addr[32*gidx_c +: 32];
                    id_d            = ID_W'(gidx_c);
                    rr_ptr_d        = ID_W'((gidx_c + 1) % NUM_REQ);
                    best_hit_d      = 1'b0;
                    best_prefix_d   = 32'h0;
                    best_len_d      = 6'd0;
                    k_d             = '0;
                    state_d         = S_SEARCH;
                end
            end
            S_SEARCH: begin
                // Strictly-longer replacement keeps the lower index on equal lengths.
                if (tbl_valid_q[k_q] && (((addr_q ^ tbl_prefix_q[k_q]) & mask_c) == 32'h0) &&
                    (!best_hit_q || (tbl_len_q[k_q] > best_len_q))) begin
                    best_hit_d    = 1'b1;
                    best_prefix_d = tbl_prefix_q[k_q] & mask_c;
                    best_len_d    = tbl_len_q[k_q];
                end
                if (k_q == IDX_W'(NUM_ENTRIES - 1)) begin
                    resp_valid_d = 1'b1;
                    state_d      = S_RESP;
                end else begin
                    k_d = k_q + 1'b1;
                end
            end
            S_RESP: begin
                if (resp_ready) begin
                    resp_valid_d = 1'b0;
                    state_d      = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= S_IDLE;
            rr_ptr_q      <= '0;
            addr_q        <= '0;
            id_q          <= '0;
            k_q           <= '0;
            best_hit_q    <= 1'b0;
            best_prefix_q <= '0;
            best_len_q    <= '0;
            resp_valid_q  <= 1'b0;
            tbl_valid_q   <= '0;
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                tbl_prefix_q[i] <= '0;
                tbl_len_q[i]    <= '0;
            end
        end else begin
            state_q       <= state_d;
            rr_ptr_q      <= rr_ptr_d;
            addr_q        <= addr_d;
            id_q          <= id_d;
            k_q           <= k_d;
            best_hit_q    <= best_hit_d;
            best_prefix_q <= best_prefix_d;
            best_len_q    <= best_len_d;
            resp_valid_q  <= resp_valid_d;
            tbl_valid_q   <= tbl_valid_d;
            tbl_prefix_q  <= tbl_prefix_d;
            tbl_len_q     <= tbl_len_d;
        end
    end

    // The combinational handshakes are gated so every output reads 0 while reset is held.
    assign req_ready   = reset ? '0 : grant_c;
    assign cfg_ready   = !reset && (state_q == S_IDLE);
    assign resp_valid  = resp_valid_q;
    assign resp_id     = id_q;
    assign resp_hit    = best_hit_q;
    assign resp_prefix = best_prefix_q;
    assign resp_len    = best_len_q;

endmodule

// File: tb/tb_lpm_lookup_scheduler.sv
// tb/tb_lpm_lookup_scheduler.sv - directed scoreboard bench for lpm_lookup_scheduler
module tb_lpm_lookup_scheduler;

    logic         clk = 1'b0;
    logic         reset;
    logic [3:0]   req_valid;
    logic [127:0] req_addr;
    logic [3:0]   req_ready;
    logic         cfg_we;
    logic [1:0]   cfg_idx;
    logic [31:0]  cfg_prefix;
    logic [5:0]   cfg_len;
    logic         cfg_en;
    logic         cfg_ready;
    logic         resp_valid;
    logic         resp_ready;
    logic [1:0]   resp_id;
    logic         resp_hit;
    logic [31:0]  resp_prefix;
    logic [5:0]   resp_len;

    typedef struct packed {
        logic [1:0]  id;
        logic        hit;
        logic [31:0] prefix;
        logic [5:0]  len;
    } exp_t;

    exp_t sb[$];
    exp_t rr_exp[4];
    int   checks = 0;
    int   errors = 0;

    lpm_lookup_scheduler #(.NUM_REQ(4), .NUM_ENTRIES(4), .IDX_W(2), .ID_W(2)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_addr(req_addr), .req_ready(req_ready),
        .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_prefix(cfg_prefix), .cfg_len(cfg_len),
        .cfg_en(cfg_en), .cfg_ready(cfg_ready),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
        .resp_hit(resp_hit), .resp_prefix(resp_prefix), .resp_len(resp_len)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cfg_write(input logic [1:0] idx, input logic [31:0] p, input logic [5:0] l,
                             input logic en);
        @(negedge clk);
        cfg_we = 1'b1; cfg_idx = idx; cfg_prefix = p; cfg_len = l; cfg_en = en;
        #1 check("cfg_ready_idle", 64'(cfg_ready), 64'd1);
        @(posedge clk);
        #1 cfg_we = 1'b0;
    endtask

    // Raise one request and wait (bounded) for its grant; returns just after the grant edge.
    task automatic request(input int r, input logic [31:0] a);
        int n;
        @(negedge clk);
        req_valid[r] = 1'b1;
        req_addr[32*r +: 32] = a;
        n = 0;
        #1;
        while (req_ready[r] !== 1'b1 && n < 20) begin
            @(negedge clk); #1; n++;
        end
        check("grant_onehot", 64'(req_ready), 64'(4'b0001 << r));
        @(posedge clk);
        #1 req_valid[r] = 1'b0;
    endtask

    // Wait for a response, compare with the scoreboard head, hold it, then accept it.
    task automatic collect(input int hold, input logic chk_lat);
        int   lat;
        exp_t e;
        lat = 0;
        while (lat < 30) begin
            @(negedge clk); lat++;
            if (resp_valid === 1'b1) break;
        end
        check("resp_seen", 64'(resp_valid), 64'd1);
        if (chk_lat) check("latency", 64'(lat), 64'd5);
        e = sb.pop_front();
        check("resp_id", 64'(resp_id), 64'(e.id));
        check("resp_hit", 64'(resp_hit), 64'(e.hit));
        check("resp_prefix", 64'(resp_prefix), 64'(e.prefix));
        check("resp_len", 64'(resp_len), 64'(e.len));
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            check("hold_valid", 64'(resp_valid), 64'd1);
            check("hold_payload", {23'd0, resp_id, resp_hit, resp_prefix, resp_len},
                  {23'd0, e.id, e.hit, e.prefix, e.len});
        end
        resp_ready = 1'b1;
        #1 check("no_grant_in_accept", 64'(req_ready), 64'd0);
        @(posedge clk);
        #1 resp_ready = 1'b0;
        @(negedge clk);
        check("resp_drop", 64'(resp_valid), 64'd0);
    endtask

    initial begin
        reset = 1'b1; req_valid = '0; req_addr = '0; cfg_we = 1'b0; cfg_idx = '0;
        cfg_prefix = '0; cfg_len = '0; cfg_en = 1'b0; resp_ready = 1'b0;
        repeat (3) @(negedge clk);
        #1 check("rst_outputs", {req_ready, cfg_ready, resp_valid, resp_hit, resp_prefix, resp_len, resp_id}, 64'd0);
        @(negedge clk) reset = 1'b0;
        #1 check("idle_cfg_ready", 64'(cfg_ready), 64'd1);
        check("idle_resp_valid", 64'(resp_valid), 64'd0);

        // Reference table
        cfg_write(2'd0, 32'h5053_0000, 6'd16, 1'b1);
        cfg_write(2'd1, 32'h5053_C000, 6'd20, 1'b1);
        cfg_write(2'd2, 32'h5053_C500, 6'd24, 1'b1);
        cfg_write(2'd3, 32'h5053_C572, 6'd32, 1'b1);

        // Exact /32, then /24 and /16 matches
        sb.push_back('{2'd1, 1'b1, 32'h5053_C572, 6'd32});
        request(1, 32'h5053_C572); collect(0, 1'b1);
        sb.push_back('{2'd0, 1'b1, 32'h5053_C500, 6'd24});
        request(0, 32'h5053_C5FF); collect(0, 1'b1);
        sb.push_back('{2'd2, 1'b1, 32'h5053_0000, 6'd16});
        request(2, 32'h5053_1234); collect(0, 1'b1);

        // Miss, then a default route in entry 0
        sb.push_back('{2'd3, 1'b0, 32'h0, 6'd0});
        request(3, 32'h0A00_0001); collect(0, 1'b1);
        cfg_write(2'd0, 32'h0, 6'd0, 1'b1);
        sb.push_back('{2'd3, 1'b1, 32'h0, 6'd0});
        request(3, 32'h0A00_0001); collect(0, 1'b1);
        cfg_write(2'd0, 32'h5053_0000, 6'd16, 1'b1);

        // Round robin with every requester asserting; pointer is at 0 after requester 3
        rr_exp[0] = '{2'd0, 1'b1, 32'h5053_C572, 6'd32};
        rr_exp[1] = '{2'd1, 1'b1, 32'h5053_C500, 6'd24};
        rr_exp[2] = '{2'd2, 1'b1, 32'h5053_0000, 6'd16};
        rr_exp[3] = '{2'd3, 1'b0, 32'h0, 6'd0};
        @(negedge clk);
        req_addr = {32'h0A00_0001, 32'h5053_1234, 32'h5053_C5FF, 32'h5053_C572};
        req_valid = 4'hF;
        for (int g = 0; g < 5; g++) begin
            int n;
            n = 0;
            #1;
            while (req_ready === 4'b0000 && n < 20) begin
                @(negedge clk); #1; n++;
            end
            check("rr_grant", 64'(req_ready), 64'(4'b0001 << (g % 4)));
            sb.push_back(rr_exp[g % 4]);
            @(posedge clk);
            collect(0, 1'b0);
        end
        req_valid = '0;

        // Config wins over a simultaneous request; grant follows; table frozen while searching
        @(negedge clk);
        cfg_we = 1'b1; cfg_idx = 2'd2; cfg_prefix = 32'h5053_C500; cfg_len = 6'd24; cfg_en = 1'b1;
        req_valid[1] = 1'b1; req_addr[63:32] = 32'h5053_C572;
        #1 check("cfg_prio_ready", 64'(cfg_ready), 64'd1);
        check("cfg_prio_nogrant", 64'(req_ready), 64'd0);
        @(posedge clk);
        #1 cfg_we = 1'b0;
        @(negedge clk);
        #1 check("grant_after_cfg", 64'(req_ready), 64'b0010);
        sb.push_back('{2'd1, 1'b1, 32'h5053_C572, 6'd32});
        @(posedge clk);
        #1 req_valid = '0;
        cfg_we = 1'b1; cfg_idx = 2'd3; cfg_prefix = 32'h0A00_0000; cfg_len = 6'd8;
        @(negedge clk);
        check("search_cfg_ready", 64'(cfg_ready), 64'd0);
        @(posedge clk);
        #1 cfg_we = 1'b0;
        collect(0, 1'b0);

        // Back-pressure: result held stable for 5 cycles
        sb.push_back('{2'd2, 1'b1, 32'h5053_C500, 6'd24});
        request(2, 32'h5053_C5FF); collect(5, 1'b1);

        // Reset in the middle of a search
        request(0, 32'h5053_C572);
        @(negedge clk); @(negedge clk);
        reset = 1'b1;
        #1 check("midrst_outputs", {req_ready, cfg_ready, resp_valid, resp_hit, resp_prefix, resp_len, resp_id}, 64'd0);
        @(negedge clk) reset = 1'b0;
        begin
            logic seen;
            seen = 1'b0;
            repeat (10) begin
                @(negedge clk);
                if (resp_valid !== 1'b0) seen = 1'b1;
            end
            check("dropped_no_resp", 64'(seen), 64'd0);
        end
        sb.push_back('{2'd0, 1'b0, 32'h0, 6'd0});
        request(0, 32'h5053_C572); collect(0, 1'b1);

        // Disabled entry ignored; oversize length clamped to 32
        cfg_write(2'd0, 32'h0, 6'd0, 1'b0);
        cfg_write(2'd1, 32'h0A00_0001, 6'd40, 1'b1);
        sb.push_back('{2'd1, 1'b1, 32'h0A00_0001, 6'd32});
        request(1, 32'h0A00_0001); collect(0, 1'b1);
        sb.push_back('{2'd2, 1'b0, 32'h0, 6'd0});
        request(2, 32'h0A00_0000); collect(0, 1'b1);

        check("sb_empty", 64'(sb.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
